// File: rtl/mem_lsu_if.sv
// mem_lsu_if: data-memory request/response bus between the load/store unit and memory.
interface mem_lsu_if #(parameter int ADDR_W = 64);
  logic              dreq_valid;
  logic              dreq_ready;
  logic [ADDR_W-1:0] dreq_addr;
  logic              dreq_wen;
  logic [63:0]       dreq_wdata;
  logic [7:0]        dreq_wmask;
  logic              drsp_valid;
  logic [63:0]       drsp_rdata;
  modport master (
    output dreq_valid, dreq_addr, dreq_wen, dreq_wdata, dreq_wmask,
    input  dreq_ready, drsp_valid, drsp_rdata
  );
  modport slave (
    input  dreq_valid, dreq_addr, dreq_wen, dreq_wdata, dreq_wmask,
    output dreq_ready, drsp_valid, drsp_rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit; passes ALU ops through, runs memory handshakes for loads/stores.
module mem_lsu #(
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] inst_addr_i,
  input  logic [63:0] rd_wdata_i,
  input  logic [4:0]  rd_waddr_i,
  input  logic        reg_wen_i,
  input  logic        mem_ren_i,
  input  logic        mem_wen_i,
  input  logic [2:0]  funct3_i,
  input  logic [63:0] st_data_i,
  output logic [63:0] inst_addr_o,
  output logic [63:0] rd_wdata_o,
  output logic [4:0]  rd_waddr_o,
  output logic        reg_wen_o,
  output logic        stall_o,
  output logic        exc_o,
  mem_lsu_if.master   dmem
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t      state;
  logic [63:0] pc_q, res_q, sh, ld_val, sdata;
  logic [4:0]  rd_q;
  logic [2:0]  f3_q, off_q;
  logic [7:0]  smask;
  logic        ld_q, mem_op, misal, illegal, bad, start, idle, done;
  always_comb begin
    mem_op  = mem_ren_i | mem_wen_i;
    misal   = funct3_i[1:0] == 2'd1 ? rd_wdata_i[0] :
              funct3_i[1:0] == 2'd2 ? |rd_wdata_i[1:0] :
              funct3_i[1:0] == 2'd3 ? |rd_wdata_i[2:0] : 1'b0;
    illegal = (mem_ren_i & mem_wen_i) | (mem_ren_i & funct3_i == 3'b111) | (mem_wen_i & funct3_i[2]);
    bad     = mem_op & (misal | illegal);
    idle    = state == IDLE;
    done    = state == DONE;
    start   = idle & mem_op & ~bad;
    smask   = (funct3_i[1:0] == 2'd0 ? 8'h01 : funct3_i[1:0] == 2'd1 ? 8'h03 :
               funct3_i[1:0] == 2'd2 ? 8'h0F : 8'hFF) << rd_wdata_i[2:0];
    sdata   = funct3_i[1:0] == 2'd0 ? {8{st_data_i[7:0]}} :
              funct3_i[1:0] == 2'd1 ? {4{st_data_i[15:0]}} :
              funct3_i[1:0] == 2'd2 ? {2{st_data_i[31:0]}} : st_data_i;
    sh      = dmem.drsp_rdata >> {off_q, 3'b000};
    ld_val  = f3_q == 3'b000 ? {{56{sh[7]}}, sh[7:0]} :
              f3_q == 3'b001 ? {{48{sh[15]}}, sh[15:0]} :
              f3_q == 3'b010 ? {{32{sh[31]}}, sh[31:0]} :
              f3_q == 3'b100 ? {56'd0, sh[7:0]} :
              f3_q == 3'b101 ? {48'd0, sh[15:0]} :
              f3_q == 3'b110 ? {32'd0, sh[31:0]} : sh;
    // Outputs are forced low while reset is held, even on the pass-through path
    inst_addr_o = !rst_n ? 64'd0 : done ? pc_q : inst_addr_i;
    rd_wdata_o  = !rst_n ? 64'd0 : done ? res_q : rd_wdata_i;
    rd_waddr_o  = !rst_n ? 5'd0 : done ? rd_q : rd_waddr_i;
    reg_wen_o   = rst_n & (done ? ld_q & |rd_q : idle & reg_wen_i & ~mem_op);
    stall_o     = rst_n & (start | state == REQ | state == WAIT);
    exc_o       = rst_n & idle & bad;
  end
  assign dmem.dreq_valid = state == REQ;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      pc_q            <= '0;
      res_q           <= '0;
      rd_q            <= '0;
      f3_q            <= '0;
      off_q           <= '0;
      ld_q            <= 1'b0;
      dmem.dreq_addr  <= '0;
      dmem.dreq_wen   <= 1'b0;
      dmem.dreq_wdata <= '0;
      dmem.dreq_wmask <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pc_q            <= inst_addr_i;
          res_q           <= rd_wdata_i;
          rd_q            <= rd_waddr_i;
          f3_q            <= funct3_i;
          off_q           <= rd_wdata_i[2:0];
          ld_q            <= mem_ren_i;
          dmem.dreq_addr  <= {rd_wdata_i[ADDR_W-1:3], 3'b000};
          dmem.dreq_wen   <= mem_wen_i;
          dmem.dreq_wdata <= mem_wen_i ? sdata : 64'd0;
          dmem.dreq_wmask <= mem_wen_i ? smask : 8'd0;
          state           <= REQ;
        end
        REQ:  if (dmem.dreq_ready) state <= ld_q ? WAIT : DONE;
        WAIT: if (dmem.drsp_valid) begin
          res_q <= ld_val;
          state <= DONE;
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed scoreboard bench; stimulus queues expected MEM/WB results and memory requests, monitors pop and compare.
module tb_mem_lsu;
  logic        clk = 0, rst_n = 0;
  logic [63:0] inst_addr_i = 0, rd_wdata_i = 0, st_data_i = 0;
  logic [4:0]  rd_waddr_i = 0;
  logic        reg_wen_i = 0, mem_ren_i = 0, mem_wen_i = 0;
  logic [2:0]  funct3_i = 0;
  logic [63:0] inst_addr_o, rd_wdata_o;
  logic [4:0]  rd_waddr_o;
  logic        reg_wen_o, stall_o, exc_o;
  mem_lsu_if #(.ADDR_W(64)) bus();
  mem_lsu dut (
    .clk(clk), .rst_n(rst_n), .inst_addr_i(inst_addr_i), .rd_wdata_i(rd_wdata_i),
    .rd_waddr_i(rd_waddr_i), .reg_wen_i(reg_wen_i), .mem_ren_i(mem_ren_i), .mem_wen_i(mem_wen_i),
    .funct3_i(funct3_i), .st_data_i(st_data_i), .inst_addr_o(inst_addr_o), .rd_wdata_o(rd_wdata_o),
    .rd_waddr_o(rd_waddr_o), .reg_wen_o(reg_wen_o), .stall_o(stall_o), .exc_o(exc_o), .dmem(bus)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [63:0] pc, wd; logic [4:0] rd; logic wen, exc;} out_t;
  typedef struct packed {logic [63:0] addr, wdata; logic [7:0] mask; logic wen;} req_t;
  out_t oq[$];
  req_t rq[$];
  int   cyc = 0, total = 0, fails = 0, last_done = 0, vstart = 0;
  logic active = 0;
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && active && !stall_o) begin
      if (oq.size() == 0) begin
        total++; fails++;
        $display("FAIL mwb_out unexpected output pc=%h", inst_addr_o);
      end else chk("mwb_out", {inst_addr_o, rd_wdata_o, rd_waddr_o, reg_wen_o, exc_o}, oq.pop_front());
    end
    if (bus.dreq_valid && bus.dreq_ready) begin
      if (rq.size() == 0) begin
        total++; fails++;
        $display("FAIL dreq unexpected request addr=%h", bus.dreq_addr);
      end else chk("dreq", {bus.dreq_addr, bus.dreq_wdata, bus.dreq_wmask, bus.dreq_wen}, rq.pop_front());
    end
  end
  task automatic op(input string nm, input logic [63:0] pc, a, st, input logic [4:0] rd,
                    input logic rw, ren, wen, input logic [2:0] f3, input int rdly,
                    input logic [63:0] rdata, input out_t eo, input logic req, input req_t er,
                    input int esc, input int evc);
    int   sc = 0, vc = 0, n = 0;
    logic pend = 0;
    oq.push_back(eo);
    if (req) rq.push_back(er);
    active = 1;
    inst_addr_i = pc; rd_wdata_i = a; st_data_i = st; rd_waddr_i = rd;
    reg_wen_i = rw; mem_ren_i = ren; mem_wen_i = wen; funct3_i = f3;
    #1;
    forever begin
      bus.drsp_valid = pend;
      bus.drsp_rdata = pend ? rdata : 64'd0;
      pend = 0;
      if (stall_o) sc++;
      if (bus.dreq_valid) begin
        vc++;
        if (vc == 1) vstart = cyc;
      end
      bus.dreq_ready = bus.dreq_valid && vc > rdly;
      if (bus.dreq_ready && ren) pend = 1;
      if (!stall_o) break;
      n++;
      if (n > 40) begin
        total++; fails++;
        $display("FAIL %s timeout stall_o stuck", nm);
        break;
      end
      @(posedge clk); #1;
    end
    last_done = cyc;
    chk({nm, "_stall_cycles"}, sc, esc);
    chk({nm, "_req_cycles"}, vc, evc);
    @(posedge clk); #1;
    active = 0;
    bus.dreq_ready = 0; bus.drsp_valid = 0;
    reg_wen_i = 0; mem_ren_i = 0; mem_wen_i = 0;
  endtask
  initial begin
    int d;
    bus.dreq_ready = 0; bus.drsp_valid = 0; bus.drsp_rdata = 0;
    rd_wdata_i = 64'h1234; reg_wen_i = 1; rd_waddr_i = 5; inst_addr_i = 64'h99;
    #2;
    chk("reset_out", {stall_o, exc_o, reg_wen_o, rd_wdata_o, rd_waddr_o, inst_addr_o}, 0);
    chk("reset_dreq", {bus.dreq_valid, bus.dreq_addr, bus.dreq_wen, bus.dreq_wdata, bus.dreq_wmask}, 0);
    reg_wen_i = 0;
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    op("add", 64'h100, 64'h1234, 0, 5, 1, 0, 0, 3'b000, 0, 0,
       out_t'{64'h100, 64'h1234, 5'd5, 1'b1, 1'b0}, 0, req_t'{64'h0, 64'h0, 8'h0, 1'b0}, 0, 0);
    op("lb", 64'h104, 64'h1003, 0, 6, 1, 1, 0, 3'b000, 0, 64'h0000_0000_8000_0000,
       out_t'{64'h104, 64'hFFFF_FFFF_FFFF_FF80, 5'd6, 1'b1, 1'b0}, 1, req_t'{64'h1000, 64'h0, 8'h00, 1'b0}, 3, 1);
    op("lbu", 64'h108, 64'h1003, 0, 6, 1, 1, 0, 3'b100, 0, 64'h0000_0000_8000_0000,
       out_t'{64'h108, 64'h80, 5'd6, 1'b1, 1'b0}, 1, req_t'{64'h1000, 64'h0, 8'h00, 1'b0}, 3, 1);
    op("sh", 64'h10c, 64'h2006, 64'hABCD, 0, 0, 0, 1, 3'b001, 2, 0,
       out_t'{64'h10c, 64'h2006, 5'd0, 1'b0, 1'b0}, 1, req_t'{64'h2000, 64'hABCD_ABCD_ABCD_ABCD, 8'hC0, 1'b1}, 4, 3);
    op("lw_misal", 64'h110, 64'h3002, 0, 7, 1, 1, 0, 3'b010, 0, 0,
       out_t'{64'h110, 64'h3002, 5'd7, 1'b0, 1'b1}, 0, req_t'{64'h0, 64'h0, 8'h0, 1'b0}, 0, 0);
    op("lh", 64'h114, 64'h5002, 0, 8, 1, 1, 0, 3'b001, 1, 64'h0000_0000_F234_0000,
       out_t'{64'h114, 64'hFFFF_FFFF_FFFF_F234, 5'd8, 1'b1, 1'b0}, 1, req_t'{64'h5000, 64'h0, 8'h00, 1'b0}, 4, 2);
    op("lwu", 64'h118, 64'h6004, 0, 9, 1, 1, 0, 3'b110, 0, 64'h8765_4321_0000_0000,
       out_t'{64'h118, 64'h0000_0000_8765_4321, 5'd9, 1'b1, 1'b0}, 1, req_t'{64'h6000, 64'h0, 8'h00, 1'b0}, 3, 1);
    op("lw", 64'h11c, 64'h6004, 0, 9, 1, 1, 0, 3'b010, 0, 64'h8765_4321_0000_0000,
       out_t'{64'h11c, 64'hFFFF_FFFF_8765_4321, 5'd9, 1'b1, 1'b0}, 1, req_t'{64'h6000, 64'h0, 8'h00, 1'b0}, 3, 1);
    op("sb", 64'h120, 64'h7005, 64'h1111_2222_3333_445A, 0, 0, 0, 1, 3'b000, 0, 0,
       out_t'{64'h120, 64'h7005, 5'd0, 1'b0, 1'b0}, 1, req_t'{64'h7000, 64'h5A5A_5A5A_5A5A_5A5A, 8'h20, 1'b1}, 2, 1);
    op("sw", 64'h124, 64'h7004, 64'h1122_3344_DEAD_BEEF, 0, 0, 0, 1, 3'b010, 0, 0,
       out_t'{64'h124, 64'h7004, 5'd0, 1'b0, 1'b0}, 1, req_t'{64'h7000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hF0, 1'b1}, 2, 1);
    op("st_illegal", 64'h128, 64'h7000, 64'h1, 0, 0, 0, 1, 3'b100, 0, 0,
       out_t'{64'h128, 64'h7000, 5'd0, 1'b0, 1'b1}, 0, req_t'{64'h0, 64'h0, 8'h0, 1'b0}, 0, 0);
    op("ld_illegal", 64'h12c, 64'h7000, 0, 3, 1, 1, 0, 3'b111, 0, 0,
       out_t'{64'h12c, 64'h7000, 5'd3, 1'b0, 1'b1}, 0, req_t'{64'h0, 64'h0, 8'h0, 1'b0}, 0, 0);
    op("ren_wen", 64'h130, 64'h7000, 0, 3, 1, 1, 1, 3'b011, 0, 0,
       out_t'{64'h130, 64'h7000, 5'd3, 1'b0, 1'b1}, 0, req_t'{64'h0, 64'h0, 8'h0, 1'b0}, 0, 0);
    op("ld_x0", 64'h134, 64'h7000, 0, 0, 1, 1, 0, 3'b011, 0, 64'h55,
       out_t'{64'h134, 64'h55, 5'd0, 1'b0, 1'b0}, 1, req_t'{64'h7000, 64'h0, 8'h00, 1'b0}, 3, 1);
    op("sh_misal", 64'h138, 64'h7001, 64'h1, 0, 0, 0, 1, 3'b001, 0, 0,
       out_t'{64'h138, 64'h7001, 5'd0, 1'b0, 1'b1}, 0, req_t'{64'h0, 64'h0, 8'h0, 1'b0}, 0, 0);
    op("b2b_ld", 64'h13c, 64'h8, 0, 7, 1, 1, 0, 3'b011, 0, 64'h0123_4567_89AB_CDEF,
       out_t'{64'h13c, 64'h0123_4567_89AB_CDEF, 5'd7, 1'b1, 1'b0}, 1, req_t'{64'h8, 64'h0, 8'h00, 1'b0}, 3, 1);
    d = last_done;
    op("b2b_sd", 64'h140, 64'h10, 64'hCAFE_BABE_0BAD_F00D, 0, 0, 0, 1, 3'b011, 0, 0,
       out_t'{64'h140, 64'h10, 5'd0, 1'b0, 1'b0}, 1, req_t'{64'h10, 64'hCAFE_BABE_0BAD_F00D, 8'hFF, 1'b1}, 2, 1);
    chk("b2b_gap", vstart - d, 2);
    // Load aborted by reset while waiting for its response
    inst_addr_i = 64'h144; rd_wdata_i = 64'h4000; rd_waddr_i = 9; reg_wen_i = 1;
    mem_ren_i = 1; funct3_i = 3'b011;
    rq.push_back(req_t'{64'h4000, 64'h0, 8'h00, 1'b0});
    @(posedge clk); #1 bus.dreq_ready = 1;
    @(posedge clk); #1 bus.dreq_ready = 0;
    rst_n = 0;
    #1;
    chk("abort_out", {stall_o, exc_o, reg_wen_o, rd_wdata_o, rd_waddr_o, inst_addr_o}, 0);
    chk("abort_dreq", {bus.dreq_valid, bus.dreq_addr, bus.dreq_wen, bus.dreq_wdata, bus.dreq_wmask}, 0);
    mem_ren_i = 0; reg_wen_i = 0;
    @(posedge clk); #1 rst_n = 1;
    bus.drsp_valid = 1; bus.drsp_rdata = 64'hDEAD;
    @(posedge clk); #1;
    chk("abort_idle", {stall_o, bus.dreq_valid, reg_wen_o, rd_wdata_o}, {3'b000, 64'h4000});
    bus.drsp_valid = 0;
    @(posedge clk); #1;
    chk("abort_still_idle", {stall_o, bus.dreq_valid, rd_wdata_o}, {2'b00, 64'h4000});
    chk("outq_empty", oq.size(), 0);
    chk("reqq_empty", rq.size(), 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit of the RV64 pipeline, between the EX/MEM register and the MEM/WB register.
- Non-memory ops pass through combinationally. Loads and stores run a valid/ready request to data memory, with a response wait for loads.
- Stalls upstream while busy and delivers the aligned, sign/zero-extended result to MEM/WB.

Parameters:
- ADDR_W, 64, width of data-memory address.
- TIMEOUT, 0, reserved; 0 = no response timeout (the only supported value).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- inst_addr_i  in  64  PC of instruction in MEM.
- rd_wdata_i  in  64  ALU result; effective address for loads/stores.
- rd_waddr_i  in  5  destination register.
- reg_wen_i  in  1  register write enable from EX.
- mem_ren_i  in  1  load instruction.
- mem_wen_i  in  1  store instruction.
- funct3_i  in  3  access size/sign (RV64 encoding).
- st_data_i  in  64  store source (rs2).
- inst_addr_o  out  64  PC to MEM/WB.
- rd_wdata_o  out  64  writeback data to MEM/WB.
- rd_waddr_o  out  5  destination to MEM/WB.
- reg_wen_o  out  1  write enable to MEM/WB.
- stall_o  out  1  hold EX/MEM and earlier stages; MEM/WB takes reg_wen_o=0 bubble.
- exc_o  out  1  misaligned/illegal access flag, one cycle.
- dreq_valid_o  out  1  data-memory request valid.
- dreq_ready_i  in  1  memory accepts request.
- dreq_addr_o  out  ADDR_W  8-byte-aligned address (addr[2:0]=0).
- dreq_wen_o  out  1  1 = write.
- dreq_wdata_o  out  64  lane-shifted store data.
- dreq_wmask_o  out  8  byte enables (writes only; 0 for reads).
- drsp_valid_i  in  1  read data valid.
- drsp_rdata_i  in  64  aligned 64-bit read data.

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0: stall_o, exc_o, dreq_*, reg_wen_o, rd_*, inst_addr_o. Reset mid-transaction aborts immediately; dreq_valid_o drops without handshake, and any later drsp_valid_i is ignored.
- FSM: IDLE, REQ, WAIT, DONE.
- IDLE, no mem op: outputs = inputs combinationally; stall_o=0; zero latency.
- IDLE, mem op, aligned/legal: capture addr, funct3, st_data, rd_waddr, inst_addr; stall_o=1; reg_wen_o=0; go REQ.
- IDLE, misaligned or illegal: exc_o=1 for that cycle, reg_wen_o=0, no request, no stall, stay IDLE.
  - Misaligned: H with addr[0]≠0; W with addr[1:0]≠0; D with addr[2:0]≠0.
  - Illegal: load funct3=111; store funct3[2]=1.
- REQ: dreq_valid_o=1. Address/wdata/wmask/wen held stable until dreq_ready_i. On handshake: store → DONE, load → WAIT. stall_o=1.
- WAIT: stall_o=1. drsp_valid_i is ignored in the handshake cycle (earliest response is next cycle). On drsp_valid_i: extract and extend, register result, go DONE.
- DONE: stall_o=0. Outputs = captured values; reg_wen_o=1 for loads with rd≠0, 0 for stores. Next state IDLE. The upstream instruction advances on this edge.
- Load extract, off=addr[2:0], data shifted right by 8*off:
  - LB 000 sext8, LH 001 sext16, LW 010 sext32, LD 011 full.
  - LBU 100 zext8, LHU 101 zext16, LWU 110 zext32.
- Store encode:
  - SB: wmask=8'h01<<off, wdata={8{b}}.
  - SH: wmask=8'h03<<off, wdata={4{h}}.
  - SW: wmask=8'h0F<<off, wdata={2{w}}.
  - SD: wmask=8'hFF, wdata=st_data.
- Simultaneous mem_ren_i and mem_wen_i: treated as illegal (exc_o).
- Latency: store ≥3 cycles (IDLE, REQ, DONE). Load ≥4 cycles. Each ready/valid wait cycle adds 1.
- No timeout; WAIT holds indefinitely.

Test Plan:
- ADD result 64'h1234, rd=5, reg_wen_i=1, no mem -> same cycle rd_wdata_o=64'h1234, reg_wen_o=1, stall_o=0.
- LB addr 64'h1003, memory word 64'h0000_0000_8000_0000, ready=1, rsp next cycle -> dreq_addr_o=64'h1000, wmask=0; DONE rd_wdata_o=64'hFFFF_FFFF_FFFF_FF80; LBU same -> 64'h80; stall_o high exactly 3 cycles.
- SH addr 64'h2006, st_data=64'hABCD, dreq_ready_i low 2 cycles -> dreq_valid_o held 3 cycles with addr 64'h2000, wmask=8'hC0, wdata=64'hABCD_ABCD_ABCD_ABCD; reg_wen_o=0 in DONE.
- LW addr 64'h3002 -> exc_o=1 one cycle, no dreq_valid_o, reg_wen_o=0, stall_o=0.
- LD addr 64'h4000 handshaked, rst low in WAIT, then drsp_valid_i arrives -> outputs 0 immediately, FSM IDLE, response ignored.
- Back-to-back LD 64'h8 then SD 64'h10 -> second request issued the cycle after first DONE; no request overlap.
